// File: rtl/dram_burst_model.sv
// rtl/dram_burst_model.sv - behavioural DRAM burst model with RL/WL/BL mode registers
// Commands ride per-latency shift pipes; one active read and one active write burst at a time.
module dram_burst_model #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int MAXLAT = 32,
  parameter int HOLD   = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          R,
  input  logic          W,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DQ_IN_DELAY,
  input  logic          DRIV_VALID,
  input  logic [7:0]    MR_IN,
  input  logic          MRW,
  input  logic          MRR,
  input  logic          ERR_CLR,
  output logic          DQ_IE,
  output logic          DQ_OE,
  output logic [DW-1:0] DQ_OUT,
  output logic          DQ_OUT_VALID,
  output logic [7:0]    MR_OUT,
  output logic [2:0]    ERR
);

  localparam int LIDX = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam int HW   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [7:0] LP_MAXLAT = 8'(MAXLAT);

  logic [DW-1:0]     r_mem [2**AW];
  logic [7:0]        r_mr0, r_mr1;
  logic [1:0]        r_mr2;
  logic [MAXLAT-1:0] r_rd_v, r_wr_v;
  logic [AW-1:0]     r_rd_pa [MAXLAT];
  logic [AW-1:0]     r_wr_pa [MAXLAT];
  logic              r_rd_act, r_wr_act;
  logic [2:0]        r_rd_k, r_wr_k;
  logic [AW-1:0]     r_rd_base, r_wr_base, r_wr_addr;
  logic [HW-1:0]     r_hold;
  logic              r_dq_ie, r_dq_oe, r_dq_out_valid;
  logic [DW-1:0]     r_dq_out;
  logic [7:0]        r_mr_out;
  logic [2:0]        r_err;

  logic [2:0]      w_bl_m1;
  logic [AW-1:0]   w_mask;
  logic [LIDX-1:0] w_rl_idx, w_wl_idx;
  logic            w_rd_start, w_rd_beat, w_wr_start, w_wr_beat, w_busy, w_mrw_rej;
  logic [AW-1:0]   w_rd_b, w_wr_b, w_rd_addr, w_wr_addr;
  logic [2:0]      w_rd_kk, w_wr_kk;
  logic [7:0]      w_clamp;

  always_comb begin
    w_bl_m1 = 3'd0;
    case (r_mr2)
      2'd0: w_bl_m1 = 3'd0;
      2'd1: w_bl_m1 = 3'd1;
      2'd2: w_bl_m1 = 3'd3;
      default: w_bl_m1 = 3'd7;
    endcase
  end

  always_comb begin
    w_clamp = MR_IN;
    if (MR_IN == 8'd0) w_clamp = 8'd1;
    else if (MR_IN > LP_MAXLAT) w_clamp = LP_MAXLAT;
  end

  assign w_mask     = AW'(w_bl_m1);
  assign w_rl_idx   = LIDX'(r_mr0 - 8'd1);
  assign w_wl_idx   = LIDX'(r_mr1 - 8'd1);

  // Slot 0 of a pipe reaching valid means this edge is edge RL (or WL) of that command.
  assign w_rd_start = r_rd_v[0];
  assign w_rd_beat  = w_rd_start | r_rd_act;
  assign w_rd_b     = w_rd_start ? r_rd_pa[0] : r_rd_base;
  assign w_rd_kk    = w_rd_start ? 3'd0 : r_rd_k;
  assign w_rd_addr  = (w_rd_b & ~w_mask) | ((w_rd_b + AW'(w_rd_kk)) & w_mask);

  assign w_wr_start = r_wr_v[0];
  assign w_wr_beat  = w_wr_start | r_wr_act;
  assign w_wr_b     = w_wr_start ? r_wr_pa[0] : r_wr_base;
  assign w_wr_kk    = w_wr_start ? 3'd0 : r_wr_k;
  assign w_wr_addr  = (w_wr_b & ~w_mask) | ((w_wr_b + AW'(w_wr_kk)) & w_mask);

  assign w_busy    = (|r_rd_v) | (|r_wr_v) | r_rd_act | r_wr_act | r_dq_ie | r_dq_oe;
  assign w_mrw_rej = MRW & w_busy;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < MAXLAT - 1; i++) begin
      r_rd_pa[i] <= r_rd_pa[i+1];
      r_wr_pa[i] <= r_wr_pa[i+1];
    end
    if (R) r_rd_pa[w_rl_idx] <= ADDR;
    if (W) r_wr_pa[w_wl_idx] <= ADDR;
  end

  // r_dq_ie is cleared asynchronously, so a reset mid-burst blocks any further array write.
  always_ff @(posedge CLK) begin
    if (r_dq_ie && DRIV_VALID) r_mem[r_wr_addr] <= DQ_IN_DELAY;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mr0 <= 8'd2; r_mr1 <= 8'd1; r_mr2 <= 2'd0;
      r_rd_v <= '0; r_wr_v <= '0;
      r_rd_act <= 1'b0; r_wr_act <= 1'b0;
      r_rd_k <= 3'd0; r_wr_k <= 3'd0;
      r_rd_base <= '0; r_wr_base <= '0; r_wr_addr <= '0;
      r_hold <= '0;
      r_dq_ie <= 1'b0; r_dq_oe <= 1'b0; r_dq_out_valid <= 1'b0; r_dq_out <= '0;
      r_mr_out <= 8'd0; r_err <= 3'd0;
    end else begin
      r_rd_v <= {1'b0, r_rd_v[MAXLAT-1:1]};
      r_wr_v <= {1'b0, r_wr_v[MAXLAT-1:1]};
      if (R) r_rd_v[w_rl_idx] <= 1'b1;
      if (W) r_wr_v[w_wl_idx] <= 1'b1;

      if (w_rd_beat) begin
        r_dq_oe        <= 1'b1;
        r_dq_out_valid <= 1'b1;
        r_dq_out       <= r_mem[w_rd_addr];
        r_hold         <= HW'(HOLD);
        r_rd_base      <= w_rd_b;
        r_rd_k         <= w_rd_kk + 3'd1;
        r_rd_act       <= (w_rd_kk != w_bl_m1);
      end else begin
        r_dq_oe <= 1'b0;
        if (r_hold != '0) begin
          r_hold <= r_hold - HW'(1);
        end else begin
          r_dq_out_valid <= 1'b0;
          r_dq_out       <= '0;
        end
      end

      if (w_wr_beat) begin
        r_dq_ie   <= 1'b1;
        r_wr_addr <= w_wr_addr;
        r_wr_base <= w_wr_b;
        r_wr_k    <= w_wr_kk + 3'd1;
        r_wr_act  <= (w_wr_kk != w_bl_m1);
      end else begin
        r_dq_ie <= 1'b0;
      end

      r_err <= (ERR_CLR ? 3'd0 : r_err) |
               {w_mrw_rej, w_wr_start & r_wr_act, w_rd_start & r_rd_act};

      if (MRR) begin
        case (ADDR[1:0])
          2'd0:    r_mr_out <= r_mr0;
          2'd1:    r_mr_out <= r_mr1;
          2'd2:    r_mr_out <= {6'b0, r_mr2};
          default: r_mr_out <= 8'd0;
        endcase
      end

      if (MRW && !w_busy) begin
        case (ADDR[1:0])
          2'd0:    r_mr0 <= w_clamp;
          2'd1:    r_mr1 <= w_clamp;
          2'd2:    r_mr2 <= MR_IN[1:0];
          default: ;
        endcase
      end
    end
  end

  assign DQ_IE        = r_dq_ie;
  assign DQ_OE        = r_dq_oe;
  assign DQ_OUT       = r_dq_out;
  assign DQ_OUT_VALID = r_dq_out_valid;
  assign MR_OUT       = r_mr_out;
  assign ERR          = r_err;

endmodule

// File: tb/tb_dram_burst_model.sv
// tb/tb_dram_burst_model.sv - self-checking bench for dram_burst_model
// Read beats are predicted into a scoreboard at command time and matched by a monitor.
module tb_dram_burst_model;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       R = 1'b0, W = 1'b0;
  logic [7:0] ADDR = 8'd0;
  logic [7:0] DQ_IN_DELAY = 8'd0;
  logic       DRIV_VALID = 1'b0;
  logic [7:0] MR_IN = 8'd0;
  logic       MRW = 1'b0, MRR = 1'b0, ERR_CLR = 1'b0;
  logic       DQ_IE, DQ_OE, DQ_OUT_VALID;
  logic [7:0] DQ_OUT, MR_OUT;
  logic [2:0] ERR;

  dram_burst_model #(.DW(8), .AW(8), .MAXLAT(32), .HOLD(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .R(R), .W(W), .ADDR(ADDR),
    .DQ_IN_DELAY(DQ_IN_DELAY), .DRIV_VALID(DRIV_VALID), .MR_IN(MR_IN),
    .MRW(MRW), .MRR(MRR), .ERR_CLR(ERR_CLR),
    .DQ_IE(DQ_IE), .DQ_OE(DQ_OE), .DQ_OUT(DQ_OUT), .DQ_OUT_VALID(DQ_OUT_VALID),
    .MR_OUT(MR_OUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [1:0] a;
    logic [7:0] v;
    logic [7:0] exp;
  } mr_vec_t;

  beat_t      sb[$];
  beat_t      b;
  mr_vec_t    tbl[10];
  logic [7:0] tb_mem [256];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] wrap(input logic [7:0] a, input int bl, input int k);
    logic [7:0] m;
    m = 8'(bl - 1);
    return (a & ~m) | (8'(int'(a) + k) & m);
  endfunction

  task automatic do_write(input logic [7:0] a, input int bl, input int wl,
                          input logic [63:0] d, input logic [7:0] vm);
    ADDR = a; W = 1'b1; step(); W = 1'b0;
    chk("wr_ie_early", DQ_IE, 0);
    repeat (wl) step();
    for (int k = 0; k < bl; k++) begin
      chk("wr_ie_beat", DQ_IE, 1);
      DQ_IN_DELAY = d[8*k +: 8];
      DRIV_VALID  = vm[k];
      if (vm[k]) tb_mem[wrap(a, bl, k)] = d[8*k +: 8];
      step();
    end
    DRIV_VALID = 1'b0;
    chk("wr_ie_end", DQ_IE, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int bl, input int rl, input int nb);
    beat_t e;
    for (int k = 0; k < nb; k++) begin
      e.cyc  = cyc + 1 + rl + k;
      e.addr = wrap(a, bl, k);
      e.data = tb_mem[e.addr];
      sb.push_back(e);
    end
    ADDR = a; R = 1'b1; step(); R = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) step();
    step();
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic mrw(input logic [1:0] a, input logic [7:0] v);
    ADDR = {6'b0, a}; MR_IN = v; MRW = 1'b1; step(); MRW = 1'b0;
  endtask

  task automatic mrr(input logic [1:0] a, output logic [7:0] v);
    ADDR = {6'b0, a}; MRR = 1'b1; step(); MRR = 1'b0;
    v = MR_OUT;
  endtask

  always begin
    @(posedge CLK);
    #3;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_beat_missing: addr 0x%0h due cycle %0d got DQ_OE=0, required DQ_OE=1",
               sb[0].addr, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (DQ_OE === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rd_beat_unexpected: got DQ_OE=1 DQ_OUT=0x%0h at cycle %0d, required DQ_OE=0",
                 DQ_OUT, cyc);
      end else begin
        b = sb.pop_front();
        if (b.cyc != cyc || DQ_OUT !== b.data) begin
          n_bad++;
          $display("FAIL rd_beat: addr 0x%0h got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                   b.addr, DQ_OUT, cyc, b.data, b.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 8'd0,   8'd1};
    tbl[1] = '{2'd0, 8'd200, 8'd32};
    tbl[2] = '{2'd0, 8'd32,  8'd32};
    tbl[3] = '{2'd0, 8'd5,   8'd5};
    tbl[4] = '{2'd1, 8'd0,   8'd1};
    tbl[5] = '{2'd1, 8'd33,  8'd32};
    tbl[6] = '{2'd1, 8'd7,   8'd7};
    tbl[7] = '{2'd2, 8'd2,   8'd2};
    tbl[8] = '{2'd2, 8'hFF,  8'd3};
    tbl[9] = '{2'd3, 8'h55,  8'd0};

    repeat (3) step();
    chk("rst_dq_oe", DQ_OE, 0);
    chk("rst_dq_ie", DQ_IE, 0);
    chk("rst_dq_out", DQ_OUT, 0);
    chk("rst_valid", DQ_OUT_VALID, 0);
    chk("rst_mr_out", MR_OUT, 0);
    chk("rst_err", ERR, 0);
    RST_N = 1'b1;
    step();
    mrr(2'd0, got); chk("dflt_mr0", got, 2);
    mrr(2'd1, got); chk("dflt_mr1", got, 1);
    mrr(2'd2, got); chk("dflt_mr2", got, 0);

    // Default BL1/WL1/RL2: write then read with hold window
    do_write(8'h10, 1, 1, 64'hA5, 8'h01);
    do_read(8'h10, 1, 2, 1);
    step(); step();
    chk("r19_oe", DQ_OE, 1);
    chk("r19_out", DQ_OUT, 8'hA5);
    chk("r19_valid", DQ_OUT_VALID, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("r19_hold_valid", DQ_OUT_VALID, 1);
      chk("r19_hold_oe", DQ_OE, 0);
      chk("r19_hold_out", DQ_OUT, 8'hA5);
    end
    step();
    chk("r19_end_valid", DQ_OUT_VALID, 0);
    chk("r19_end_out", DQ_OUT, 0);

    // Same-edge R and W; write beat and read beat coincide on 0x10
    b.cyc = cyc + 1 + 2; b.addr = 8'h10; b.data = tb_mem[8'h10];
    sb.push_back(b);
    ADDR = 8'h10; R = 1'b1; W = 1'b1; step(); R = 1'b0; W = 1'b0;
    step();
    chk("r13_ie", DQ_IE, 1);
    DQ_IN_DELAY = 8'h3C; DRIV_VALID = 1'b1;
    step();
    DRIV_VALID = 1'b0;
    tb_mem[8'h10] = 8'h3C;
    drain();
    do_read(8'h10, 1, 2, 1);
    drain();
    chk("r13_err", ERR, 0);

    for (int i = 0; i < 10; i++) begin
      mrw(tbl[i].a, tbl[i].v);
      mrr(tbl[i].a, got);
      chk($sformatf("mr_tbl%0d", i), got, tbl[i].exp);
    end
    chk("mr_tbl_err", ERR, 0);

    mrw(2'd0, 8'd5); mrw(2'd1, 8'd1); mrw(2'd2, 8'd2);

    do_write(8'h0C, 4, 1, 64'h44332211, 8'h0F);
    do_read(8'h0E, 4, 5, 4);
    drain();

    do_write(8'h20, 4, 1, 64'h53525150, 8'h0F);
    do_write(8'h20, 4, 1, 64'h63626160, 8'h0D);
    chk("r21_model_21", tb_mem[8'h21], 8'h51);
    do_read(8'h20, 4, 5, 4);
    drain();
    chk("spaced_err", ERR, 0);

    // Reads BL apart are clean; reads 2 apart collide and truncate the first
    do_read(8'h0C, 4, 5, 4);
    repeat (3) step();
    do_read(8'h20, 4, 5, 4);
    drain();
    chk("r16_err", ERR, 0);
    do_read(8'h20, 4, 5, 2);
    step();
    do_read(8'h0C, 4, 5, 4);
    drain();
    chk("r22_err", ERR, 3'b001);
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    chk("r22_clr", ERR, 0);

    do_read(8'h0C, 4, 5, 4);
    repeat (5) step();
    mrw(2'd0, 8'd9);
    chk("r23_rej_err", ERR, 3'b100);
    drain();
    mrr(2'd0, got);
    chk("r23_mr0_kept", got, 5);

    do_write(8'h40, 4, 1, 64'h73727170, 8'h0F);
    ADDR = 8'h40; W = 1'b1; step(); W = 1'b0;
    step();
    DQ_IN_DELAY = 8'h80; DRIV_VALID = 1'b1; step();
    DQ_IN_DELAY = 8'h81; step();
    tb_mem[8'h40] = 8'h80; tb_mem[8'h41] = 8'h81;
    RST_N = 1'b0; DQ_IN_DELAY = 8'hEE;
    step(); step();
    chk("r24_ie", DQ_IE, 0);
    chk("r24_oe", DQ_OE, 0);
    chk("r24_out", DQ_OUT, 0);
    chk("r24_valid", DQ_OUT_VALID, 0);
    chk("r24_mr_out", MR_OUT, 0);
    chk("r24_err", ERR, 0);
    DRIV_VALID = 1'b0; RST_N = 1'b1;
    step();
    mrr(2'd0, got); chk("r24_mr0", got, 2);
    mrr(2'd1, got); chk("r24_mr1", got, 1);
    mrr(2'd2, got); chk("r24_mr2", got, 0);
    mrw(2'd2, 8'd2);
    do_read(8'h40, 4, 2, 4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_burst_model.md
DRAM_BURST_MODEL -- requirements
Module: dram_burst_model

Interface
REQ-001 SHALL have parameters: DW, default 8, data width; AW, default 8, address width (array depth 2^AW); MAXLAT, default 32, maximum RL/WL; HOLD, default 8, DQ_OUT hold cycles after the last read beat.
REQ-002 SHALL have these ports, clock and reset first:
  CLK  in  1  single clock; all state changes on its rising edge.
  RST_N  in  1  reset, asynchronous, active-low.
  R  in  1  read command, sampled on an edge.
  W  in  1  write command, sampled on an edge.
  ADDR  in  AW  burst base address; bits [1:0] select the mode register for MRW/MRR.
  DQ_IN_DELAY  in  DW  write beat data.
  DRIV_VALID  in  1  write beat enable (0 = masked beat).
  MR_IN  in  8  mode-register write data.
  MRW  in  1  mode-register write.
  MRR  in  1  mode-register read.
  ERR_CLR  in  1  clears ERR.
  DQ_IE  out  1  write beat window.
  DQ_OE  out  1  read beat strobe.
  DQ_OUT  out  DW  read beat data.
  DQ_OUT_VALID  out  1  DQ_OE or hold window active.
  MR_OUT  out  8  mode-register read data.
  ERR  out  3  sticky flags: [0] read collision, [1] write collision, [2] MRW rejected.

Function
REQ-003 SHALL hold mode registers MR0 = RL, MR1 = WL, MR2[1:0] = burst-length code (0/1/2/3 -> BL 1/2/4/8).
REQ-004 SHALL clamp RL/WL on MRW: 0 -> 1, greater than MAXLAT -> MAXLAT; the clamped value is the stored and read-back value.
REQ-005 SHALL, on MRR with ADDR[1:0] = 0/1/2, load MR_OUT with MR0/MR1/{6'b0,MR2[1:0]} on that edge; ADDR[1:0] = 3 SHALL load 0.
REQ-006 SHALL reject an MRW (no register change, ERR[2] set) while any read or write command is in flight or any burst is active.
REQ-007 SHALL count a command edge as edge 0; the first read beat has DQ_OE = 1 after edge RL; the first write beat has DQ_IE = 1 after edge WL.
REQ-008 SHALL output each read burst as BL consecutive cycles with DQ_OE = 1; beat k data = array at the wrapped address, read at the beat edge.
REQ-009 SHALL compute the wrapped address as base with its low log2(BL) bits replaced by (base low bits + k) mod BL.
REQ-010 SHALL assert DQ_IE for BL consecutive cycles per write burst; on beat k, if DRIV_VALID = 1, array[wrapped address] <= DQ_IN_DELAY; if DRIV_VALID = 0, the beat is masked and no write occurs.
REQ-011 SHALL accept R and W on the same edge; both proceed independently on separate paths.
REQ-012 SHALL, when a read burst is due to start while another read burst is active, set ERR[0], abort the old burst and start the new one; writes SHALL do the same with ERR[1].
REQ-013 SHALL, for any beat where a write and a read target the same address on the same edge, return the pre-write data on the read.
REQ-014 SHALL, after the last read beat, hold DQ_OUT for HOLD cycles with DQ_OUT_VALID = 1 and DQ_OE = 0, then drive DQ_OUT = 0 and DQ_OUT_VALID = 0; a new burst in the hold window cancels the hold.
REQ-015 SHALL keep ERR bits set until an edge with ERR_CLR = 1; a set event on that same edge wins.
REQ-016 SHALL support command spacing of at least BL cycles without any error flag.

Reset
REQ-017 SHALL, while RST_N = 0, force DQ_OE, DQ_IE, DQ_OUT, DQ_OUT_VALID, MR_OUT and ERR to 0, MR0 = 2, MR1 = 1, MR2 = 0 (BL 1), and clear all in-flight commands, bursts and hold counters.
REQ-018 SHALL leave array contents unchanged through reset; a reset in the middle of a burst SHALL drop the remaining beats with no array write after reset.

Verification
REQ-019 Defaults: W@A=0x10, WL=1, DRIV_VALID=1, data 0xA5; then R@0x10 -> DQ_OE high one cycle after edge 2, DQ_OUT = 0xA5, DQ_OUT_VALID high 9 cycles, then DQ_OUT = 0.
REQ-020 MR2 = 2 (BL 4), RL = 5; read @0x0E -> 4 beats from addresses 0x0E, 0x0F, 0x0C, 0x0D, first beat after edge 5.
REQ-021 BL 4 write @0x20 with DRIV_VALID pattern 1,0,1,1 -> 0x21 keeps its old value; 0x20, 0x22 and 0x23 are updated.
REQ-022 BL 4; two reads 2 cycles apart -> ERR[0] = 1, second burst is complete, first burst is truncated after 2 beats; ERR_CLR -> ERR = 0.
REQ-023 MRW RL = 0 -> MRR returns 1; MRW RL = 200 -> MRR returns MAXLAT; MRW during an active burst -> ERR[2] = 1 and MR unchanged.
REQ-024 RST_N low mid write burst -> all outputs 0, MRs at defaults, later reads show only the pre-reset beats written.
